// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   FETCH_PACKET : {inst, PC, NPC, valid} handed to the decoder
//   FETCH_STATE  : FS_RUN (fetching) / FS_HALTED (no requests after WFI)
//   NOP          : instruction presented while the packet is not valid
package fetch_stage_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } FETCH_PACKET;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } FETCH_STATE;

  localparam FETCH_PACKET EMPTY_PACKET = '{inst: NOP, PC: 32'd0, NPC: 32'd0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its neighbours (I-cache, decoder,
// branch resolution, dispatch).
//   master : the fetch stage (drives cache request, fetch packet, occupancy)
//   slave  : the environment (cache response, decoder ready, redirect, halt)
// FQ_DEPTH must match the fetch stage's FQ_DEPTH; it sizes fq_count.
interface fetch_stage_if #(
  parameter int FQ_DEPTH = 4
);
  import fetch_stage_pkg::*;

  logic                      proc2Icache_req;
  logic [31:0]               proc2Icache_addr;
  logic                      Icache2proc_valid;
  logic [63:0]               Icache2proc_data;
  logic                      dec_ready;
  logic                      redirect_en;
  logic [31:0]               redirect_pc;
  logic                      halt_in;
  FETCH_PACKET               if_packet_out;
  logic [$clog2(FQ_DEPTH):0] fq_count;

  modport master (
    output proc2Icache_req, proc2Icache_addr, if_packet_out, fq_count,
    input  Icache2proc_valid, Icache2proc_data, dec_ready,
           redirect_en, redirect_pc, halt_in
  );

  modport slave (
    input  proc2Icache_req, proc2Icache_addr, if_packet_out, fq_count,
    output Icache2proc_valid, Icache2proc_data, dec_ready,
           redirect_en, redirect_pc, halt_in
  );

endinterface

// File: rtl/fetch_stage_queue.sv
// fetch_queue: small FIFO of fetched packets between the I-cache and decoder.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   push, wdata  : write wdata at the tail
//   pop          : drop the head entry (ignored while empty)
//   flush        : discard all entries (wins over push/pop)
//   head, count  : entry at the head pointer and current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  FETCH_PACKET            wdata,
  output FETCH_PACKET            head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  FETCH_PACKET      mem [DEPTH];
  logic [PTR_W-1:0] head_ptr, tail_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  assign do_push = push;
  assign do_pop  = pop && (cnt != '0);

  // Pointer/occupancy control; storage itself is never reset.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[tail_ptr] <= wdata;
  end

  assign head  = mem[head_ptr];
  assign count = cnt;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: holds the fetch PC, issues one-word I-cache requests, buffers
// returned instructions in fetch_queue and presents the head to the decoder.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus          : fetch_stage_if.master (cache req/addr/response, decoder
//                  handshake, redirect, halt, if_packet_out, fq_count)
// Parameters: RESET_PC (PC after reset), FQ_DEPTH (queue entries, 2^n >= 2).
// Build option: define FETCH_BYPASS_EN to forward a cache response straight
// to the decoder when the queue is empty and the decoder is ready.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  FETCH_STATE       state_p0, state_d;
  logic [31:0]      pc_p0, pc_d;
  logic [CNT_W-1:0] count;
  FETCH_PACKET      head, fetched;
  logic             req, hit, bypass, push, pop, flush, q_empty;

  function automatic logic [31:0] select_word(input logic [63:0] line,
                                              input logic [31:0] pc);
    return pc[2] ? line[63:32] : line[31:0];
  endfunction

  assign q_empty = (count == '0);

  // Uses the registered (pre-pop) count, so a full queue can never overflow.
  assign req = !reset && (state_p0 == FS_RUN) &&
               (count < CNT_W'(FQ_DEPTH)) && !bus.redirect_en;
  assign hit = req && bus.Icache2proc_valid;

  assign fetched = '{inst:  select_word(bus.Icache2proc_data, pc_p0),
                     PC:    pc_p0,
                     NPC:   pc_p0 + 32'd4,
                     valid: 1'b1};

`ifdef FETCH_BYPASS_EN
  // req already implies RUN and no redirect.
  assign bypass = q_empty && hit && bus.dec_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push  = hit && !bypass;
  assign pop   = !q_empty && bus.dec_ready;
  // Halt in HALTED also flushes, but the queue is already empty there.
  assign flush = bus.redirect_en || bus.halt_in;

  // Next PC / state; redirect dominates halt.
  always_comb begin
    state_d = state_p0;
    pc_d    = pc_p0;
    if (bus.redirect_en) begin
      state_d = FS_RUN;
      pc_d    = bus.redirect_pc & ~32'd3;
    end else begin
      if (hit)         pc_d    = pc_p0 + 32'd4;
      if (bus.halt_in) state_d = FS_HALTED;
    end
  end

  // ---- stage p0: fetch PC and FSM state ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0 <= FS_RUN;
      pc_p0    <= RESET_PC;
    end else begin
      state_p0 <= state_d;
      pc_p0    <= pc_d;
    end
  end

  // ---- stage p1: registered fetch queue ----
  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (fetched),
    .head  (head),
    .count (count)
  );

  // Stale storage is masked with a NOP packet whenever the queue is empty.
  always_comb begin
    bus.if_packet_out = EMPTY_PACKET;
    if (!q_empty)    bus.if_packet_out = head;
    else if (bypass) bus.if_packet_out = fetched;
  end

  assign bus.proc2Icache_req  = req;
  assign bus.proc2Icache_addr = {pc_p0[31:3], 3'b000};
  assign bus.fq_count         = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based behavioural model. Honours FETCH_BYPASS_EN if defined.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 0 : 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fetch_stage_if #(.FQ_DEPTH(DEPTH)) bus ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Instruction memory contents: word at byte address a.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Cache returns the 8-byte line for whatever address is presented.
  assign bus.Icache2proc_data = {mem_word(bus.proc2Icache_addr + 32'd4),
                                 mem_word(bus.proc2Icache_addr)};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc = 32'd0;
  bit          m_halted = 1'b0;
  bit          m_init = 1'b0;
  FETCH_PACKET m_q[$];

  function automatic bit exp_req();
    return !reset && !m_halted && (m_q.size() < DEPTH) && !bus.redirect_en;
  endfunction

  function automatic FETCH_PACKET model_fetched();
    FETCH_PACKET p;
    p.inst  = mem_word(m_pc);
    p.PC    = m_pc;
    p.NPC   = m_pc + 32'd4;
    p.valid = 1'b1;
    return p;
  endfunction

  function automatic bit exp_bypass();
    return BYP && (m_q.size() == 0) && exp_req() && bus.Icache2proc_valid && bus.dec_ready;
  endfunction

  // Inputs change just after posedge, so at negedge they are the values the
  // next posedge will sample: compare first, then advance the model.
  always @(negedge clock) begin
    FETCH_PACKET ep;
    FETCH_PACKET f;
    bit er, hit, byp, pop;
    er  = exp_req();
    byp = exp_bypass();
    f   = model_fetched();
    if (m_init) begin
      check("req", 32'(bus.proc2Icache_req), 32'(er));
      if (er) check("addr", bus.proc2Icache_addr, m_pc & ~32'd7);
      check("fq_count", 32'(bus.fq_count), 32'(m_q.size()));
      if (m_q.size() > 0) ep = m_q[0];
      else if (byp)       ep = f;
      else                ep = '0;
      check("valid", 32'(bus.if_packet_out.valid), 32'(ep.valid));
      if (ep.valid && bus.if_packet_out.valid) begin
        check("pkt_inst", bus.if_packet_out.inst, ep.inst);
        check("pkt_pc",   bus.if_packet_out.PC,   ep.PC);
        check("pkt_npc",  bus.if_packet_out.NPC,  ep.NPC);
      end
    end
    hit = er && bus.Icache2proc_valid;
    pop = (m_q.size() > 0) && bus.dec_ready;
    if (reset) begin
      m_init   = 1'b1;
      m_pc     = 32'd0;
      m_halted = 1'b0;
      m_q.delete();
    end else if (m_init) begin
      if (bus.redirect_en) begin
        m_pc     = bus.redirect_pc & ~32'd3;
        m_halted = 1'b0;
        m_q.delete();
      end else begin
        if (hit) m_pc = m_pc + 32'd4;
        if (bus.halt_in) begin
          m_halted = 1'b1;
          m_q.delete();
        end else begin
          if (pop) void'(m_q.pop_front());
          if (hit && !byp) m_q.push_back(f);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_en = 1'b0;
    bus.halt_in = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    bus.Icache2proc_valid = 1'b1;
    bus.dec_ready   = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.halt_in     = 1'b0;
    reset = 1'b1;

    // Reset state
    step();
    step();
    @(negedge clock);
    check("rst_req",   32'(bus.proc2Icache_req), 32'd0);
    check("rst_valid", 32'(bus.if_packet_out.valid), 32'd0);
    check("rst_inst",  bus.if_packet_out.inst, 32'h0000_0013);
    check("rst_pc",    bus.if_packet_out.PC, 32'd0);
    check("rst_npc",   bus.if_packet_out.NPC, 32'd0);
    check("rst_count", 32'(bus.fq_count), 32'd0);
    step();
    reset = 1'b0;

    // Streaming with hits and decoder always ready
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("s_req", 32'(bus.proc2Icache_req), 32'd1);
      check("s_addr", bus.proc2Icache_addr, (32'(k) * 32'd4) & ~32'd7);
      check("s_valid", 32'(bus.if_packet_out.valid), 32'(k >= LAT));
      check("s_count", 32'(bus.fq_count), (k == 0) ? 32'd0 : 32'(LAT));
      if (k >= LAT) begin
        check("s_pc",   bus.if_packet_out.PC,   32'(k - LAT) * 32'd4);
        check("s_npc",  bus.if_packet_out.NPC,  32'(k - LAT) * 32'd4 + 32'd4);
        check("s_inst", bus.if_packet_out.inst, mem_word(32'(k - LAT) * 32'd4));
      end
      step();
    end

    // Decoder stalled: fill to DEPTH, then drain in order
    do_reset();
    bus.dec_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clock);
      check("f_req", 32'(bus.proc2Icache_req), 32'd1);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("full_count", 32'(bus.fq_count), 32'd4);
      check("full_req",   32'(bus.proc2Icache_req), 32'd0);
      step();
    end
    bus.dec_ready = 1'b1;
    @(negedge clock);
    check("d0_pc",  bus.if_packet_out.PC, 32'h0);
    check("d0_req", 32'(bus.proc2Icache_req), 32'd0);
    step();
    @(negedge clock);
    check("d1_pc",    bus.if_packet_out.PC, 32'h4);
    check("d1_req",   32'(bus.proc2Icache_req), 32'd1);
    check("d1_count", 32'(bus.fq_count), 32'd3);
    step();
    @(negedge clock);
    check("d2_pc", bus.if_packet_out.PC, 32'h8);
    step();
    @(negedge clock);
    check("d3_pc", bus.if_packet_out.PC, 32'hC);
    step();

    // Redirect with 3 queued entries and a response in flight
    do_reset();
    bus.dec_ready = 1'b0;
    step(); step(); step();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    @(negedge clock);
    check("r_count", 32'(bus.fq_count), 32'd3);
    check("r_req",   32'(bus.proc2Icache_req), 32'd0);
    check("r_valid", 32'(bus.if_packet_out.valid), 32'd1);
    step();
    bus.redirect_en = 1'b0;
    bus.Icache2proc_valid = 1'b0;
    @(negedge clock);
    check("r1_count", 32'(bus.fq_count), 32'd0);
    check("r1_addr",  bus.proc2Icache_addr, 32'h100);
    check("r1_req",   32'(bus.proc2Icache_req), 32'd1);
    check("r1_valid", 32'(bus.if_packet_out.valid), 32'd0);
    step();
    bus.Icache2proc_valid = 1'b1;
    bus.dec_ready = 1'b1;
    step();
    @(negedge clock);
    check("r3_pc", bus.if_packet_out.PC, 32'h100 + 32'(1 - LAT) * 32'd4);
    step();

    // Halt at PC 0x10, then redirect out of HALTED
    do_reset();
    step(); step(); step(); step();
    bus.halt_in = 1'b1;
    @(negedge clock);
    check("h_addr", bus.proc2Icache_addr, 32'h10);
    step();
    bus.halt_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("h_req",   32'(bus.proc2Icache_req), 32'd0);
      check("h_count", 32'(bus.fq_count), 32'd0);
      check("h_valid", 32'(bus.if_packet_out.valid), 32'd0);
      if (k == 4) bus.halt_in = 1'b1;
      else        bus.halt_in = 1'b0;
      step();
    end
    bus.halt_in = 1'b0;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect_en = 1'b0;
    @(negedge clock);
    check("hr_req",  32'(bus.proc2Icache_req), 32'd1);
    check("hr_addr", bus.proc2Icache_addr, 32'h40);
    step();

    // Redirect and halt together: redirect wins
    bus.redirect_en = 1'b1;
    bus.halt_in     = 1'b1;
    bus.redirect_pc = 32'h202;
    step();
    bus.redirect_en = 1'b0;
    bus.halt_in     = 1'b0;
    @(negedge clock);
    check("rh_req",  32'(bus.proc2Icache_req), 32'd1);
    check("rh_addr", bus.proc2Icache_addr, 32'h200);
    step();
    @(negedge clock);
    check("rh_pc", bus.if_packet_out.PC, 32'h200 + 32'(1 - LAT) * 32'd4);
    step();

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      int rdy_bias;
      rdy_bias = (i / 500) % 4;
      bus.Icache2proc_valid = ($urandom_range(0, 3) != 0);
      bus.dec_ready   = ($urandom_range(0, 3) < 32'(rdy_bias + 1));
      bus.redirect_en = ($urandom_range(0, 40) == 0);
      bus.redirect_pc = $urandom & 32'h0000_FFFF;
      bus.halt_in     = ($urandom_range(0, 80) == 0);
      reset           = ($urandom_range(0, 300) == 0);
      step();
    end
    reset = 1'b0;
    bus.redirect_en = 1'b0;
    bus.halt_in = 1'b0;
    step();
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
